// File: rtl/uart_bus_arbiter_if.sv
// Bus bundle shared by the OBI requesters, the round-robin arbiter and the UART register port.
interface uart_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ-1:0]       we_i;
    logic [NUM_REQ-1:0][3:0]  be_i;
    logic [NUM_REQ-1:0][31:0] addr_i;
    logic [NUM_REQ-1:0][31:0] data_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       rvalid_o;
    logic [NUM_REQ-1:0][31:0] rdata_o;
    logic                     slv_req_o;
    logic                     slv_we_o;
    logic [3:0]               slv_be_o;
    logic [31:0]              slv_addr_o;
    logic [31:0]              slv_data_o;
    logic [31:0]              slv_rdata_i;

    // The master view is the requester fabric plus the UART slave; the arbiter sits on the slave view.
    modport master (
        output req_i, we_i, be_i, addr_i, data_i, slv_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_data_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, data_i, slv_rdata_i,
        output gnt_o, rvalid_o, rdata_o, slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_data_o
    );
endinterface

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing one UART register port among NUM_REQ OBI requesters,
// with a one-deep response pipeline that steers slave read data back to the access owner.
module uart_bus_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_bus_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] r_rrPtr;
    logic [IDX_W-1:0] r_ownerQ;
    logic             r_respQ;

    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_nextPtr;
    logic [IDX_W-1:0] w_scanIdx;
    logic             w_anyReq;
    int               w_sum;

    assign w_anyReq = |bus.req_i;

    // Scan from the farthest offset back to the pointer so the nearest requester wins;
    // the wrap uses subtraction so a non-power-of-two NUM_REQ never yields an index out of range.
    always_comb begin
        w_winner  = '0;
        w_scanIdx = '0;
        w_sum     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = int'(r_rrPtr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_scanIdx = IDX_W'(w_sum);
            if (bus.req_i[w_scanIdx]) begin
                w_winner = w_scanIdx;
            end
        end
    end

    assign w_nextPtr = (int'(w_winner) == NUM_REQ - 1) ? '0 : w_winner + 1'b1;

    always_comb begin
        bus.gnt_o      = '0;
        bus.slv_req_o  = 1'b0;
        bus.slv_we_o   = 1'b0;
        bus.slv_be_o   = '0;
        bus.slv_addr_o = '0;
        bus.slv_data_o = '0;
        if (w_anyReq) begin
            bus.gnt_o[w_winner] = 1'b1;
            bus.slv_req_o       = 1'b1;
            bus.slv_we_o        = bus.we_i[w_winner];
            bus.slv_be_o        = bus.be_i[w_winner];
            bus.slv_addr_o      = bus.addr_i[w_winner];
            bus.slv_data_o      = bus.data_i[w_winner];
        end
    end

    // Write responses also carry slave data; the requester ignores it.
    always_comb begin
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        if (r_respQ) begin
            bus.rvalid_o[r_ownerQ] = 1'b1;
            bus.rdata_o[r_ownerQ]  = bus.slv_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rrPtr  <= '0;
            r_ownerQ <= '0;
            r_respQ  <= 1'b0;
        end else begin
            r_respQ <= w_anyReq;
            if (w_anyReq) begin
                r_rrPtr  <= w_nextPtr;
                r_ownerQ <= w_winner;
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Bench for uart_bus_arbiter: directed scenarios and random OBI traffic on a 2- and a 3-requester
// instance, compared every cycle against a queue-based reference model.
module tb_uart_bus_arbiter;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b1;

    uart_bus_arbiter_if #(.NUM_REQ(2)) bus2 ();
    uart_bus_arbiter_if #(.NUM_REQ(3)) bus3 ();

    uart_bus_arbiter #(.NUM_REQ(2)) dut2 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus2));
    uart_bus_arbiter #(.NUM_REQ(3)) dut3 (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus3));

    always #5 clk_i = ~clk_i;

    // Reference state: next-favoured requester and the response due in the coming cycle.
    int         ptr2 = 0;
    int         ptr3 = 0;
    int         due2[$];
    int         due3[$];
    logic [2:0] granted2 = '0;
    logic [2:0] granted3 = '0;

    function automatic int pickWinner(input logic [2:0] req, input int ptr, input int n);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = (ptr + k) % n;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        int w2;
        int w3;
        if (!rst_ni) begin
            ptr2 = 0;
            ptr3 = 0;
            due2.delete();
            due3.delete();
            granted2 = '0;
            granted3 = '0;
        end else begin
            w2 = pickWinner({1'b0, bus2.req_i}, ptr2, 2);
            w3 = pickWinner(bus3.req_i, ptr3, 3);
            due2.delete();
            due3.delete();
            granted2 = '0;
            granted3 = '0;
            if (w2 >= 0) begin
                due2.push_back(w2);
                ptr2 = (w2 + 1) % 2;
                granted2[w2] = 1'b1;
            end
            if (w3 >= 0) begin
                due3.push_back(w3);
                ptr3 = (w3 + 1) % 3;
                granted3[w3] = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compareBus(input string tag, input int n, input int ptr, input int dueOwner,
                              input logic [2:0] req, input logic [2:0] we, input logic [2:0][3:0] be,
                              input logic [2:0][31:0] addr, input logic [2:0][31:0] data,
                              input logic [2:0] gnt, input logic [2:0] rvalid,
                              input logic [2:0][31:0] rdata, input logic slvReq, input logic slvWe,
                              input logic [3:0] slvBe, input logic [31:0] slvAddr,
                              input logic [31:0] slvData, input logic [31:0] slvRdata);
        int               w;
        logic [2:0]       expGnt;
        logic [2:0]       expRvalid;
        logic [2:0][31:0] expRdata;
        w         = pickWinner(req, ptr, n);
        expGnt    = '0;
        expRvalid = '0;
        expRdata  = '0;
        if (w >= 0) expGnt[w] = 1'b1;
        if (dueOwner >= 0) begin
            expRvalid[dueOwner] = 1'b1;
            expRdata[dueOwner]  = slvRdata;
        end
        checkOutput({tag, ".gnt"}, 96'(gnt), 96'(expGnt));
        checkOutput({tag, ".slv_req"}, 96'(slvReq), 96'(w >= 0));
        checkOutput({tag, ".slv_we"}, 96'(slvWe), 96'((w >= 0) ? we[w] : 1'b0));
        checkOutput({tag, ".slv_be"}, 96'(slvBe), 96'((w >= 0) ? be[w] : 4'h0));
        checkOutput({tag, ".slv_addr"}, 96'(slvAddr), 96'((w >= 0) ? addr[w] : 32'h0));
        checkOutput({tag, ".slv_data"}, 96'(slvData), 96'((w >= 0) ? data[w] : 32'h0));
        checkOutput({tag, ".rvalid"}, 96'(rvalid), 96'(expRvalid));
        checkOutput({tag, ".rdata"}, 96'(rdata), 96'(expRdata));
    endtask

    always @(negedge clk_i) begin
        if (checking) begin
            compareBus("dut2", 2, ptr2, (due2.size() > 0) ? due2[0] : -1,
                       {1'b0, bus2.req_i}, {1'b0, bus2.we_i}, {4'h0, bus2.be_i},
                       {32'h0, bus2.addr_i}, {32'h0, bus2.data_i}, {1'b0, bus2.gnt_o},
                       {1'b0, bus2.rvalid_o}, {32'h0, bus2.rdata_o}, bus2.slv_req_o,
                       bus2.slv_we_o, bus2.slv_be_o, bus2.slv_addr_o, bus2.slv_data_o,
                       bus2.slv_rdata_i);
            compareBus("dut3", 3, ptr3, (due3.size() > 0) ? due3[0] : -1,
                       bus3.req_i, bus3.we_i, bus3.be_i, bus3.addr_i, bus3.data_i, bus3.gnt_o,
                       bus3.rvalid_o, bus3.rdata_o, bus3.slv_req_o, bus3.slv_we_o,
                       bus3.slv_be_o, bus3.slv_addr_o, bus3.slv_data_o, bus3.slv_rdata_i);
            checkOutput("dut2.rr_ptr", 96'(dut2.r_rrPtr), 96'(ptr2));
            checkOutput("dut3.rr_ptr", 96'(dut3.r_rrPtr), 96'(ptr3));
        end
    end

    task automatic idleAll();
        bus2.req_i = '0; bus2.we_i = '0; bus2.be_i = '0; bus2.addr_i = '0; bus2.data_i = '0;
        bus3.req_i = '0; bus3.we_i = '0; bus3.be_i = '0; bus3.addr_i = '0; bus3.data_i = '0;
        bus2.slv_rdata_i = '0;
        bus3.slv_rdata_i = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Requesters keep request and attributes until granted, then may issue something new.
    task automatic applyStimulus();
        for (int i = 0; i < 2; i++) begin
            if (!bus2.req_i[i] || granted2[i]) begin
                bus2.req_i[i]  = ($urandom_range(0, 99) < 65);
                bus2.we_i[i]   = 1'($urandom_range(0, 1));
                bus2.be_i[i]   = 4'($urandom);
                bus2.addr_i[i] = 32'($urandom_range(0, 63)) << 2;
                bus2.data_i[i] = $urandom;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!bus3.req_i[i] || granted3[i]) begin
                bus3.req_i[i]  = ($urandom_range(0, 99) < 50);
                bus3.we_i[i]   = 1'($urandom_range(0, 1));
                bus3.be_i[i]   = 4'($urandom);
                bus3.addr_i[i] = 32'($urandom_range(0, 63)) << 2;
                bus3.data_i[i] = $urandom;
            end
        end
        bus2.slv_rdata_i = $urandom;
        bus3.slv_rdata_i = $urandom;
    endtask

    initial begin
        logic [1:0] gntSeq2 [4];
        logic [2:0] gntSeq3 [4];
        gntSeq2 = '{2'b01, 2'b10, 2'b01, 2'b10};
        gntSeq3 = '{3'b001, 3'b100, 3'b001, 3'b100};
        idleAll();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset.rvalid", 96'(bus2.rvalid_o), 96'(0));
        checkOutput("reset.rdata", 96'(bus2.rdata_o), 96'(0));
        checkOutput("reset.gnt", 96'(bus2.gnt_o), 96'(0));
        checkOutput("reset.slv_req", 96'(bus2.slv_req_o), 96'(0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Single read
        bus2.req_i = 2'b01;
        bus2.be_i[0] = 4'hF;
        bus2.addr_i[0] = 32'h0000_0004;
        @(negedge clk_i);
        checkOutput("read.gnt", 96'(bus2.gnt_o), 96'(2'b01));
        checkOutput("read.slv_req", 96'(bus2.slv_req_o), 96'(1));
        checkOutput("read.slv_addr", 96'(bus2.slv_addr_o), 96'(32'h4));
        checkOutput("read.slv_we", 96'(bus2.slv_we_o), 96'(0));
        nextCycle();
        idleAll();
        bus2.slv_rdata_i = 32'hA5;
        @(negedge clk_i);
        checkOutput("read.rvalid", 96'(bus2.rvalid_o), 96'(2'b01));
        checkOutput("read.rdata", 96'(bus2.rdata_o), 96'(64'h0000_0000_0000_00A5));

        // Contention from reset
        #2 rst_ni = 1'b0;
        nextCycle();
        rst_ni = 1'b1;
        bus2.req_i = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (c < 4) checkOutput("contention.gnt", 96'(bus2.gnt_o), 96'(gntSeq2[c]));
            checkOutput("contention.rvalid", 96'(bus2.rvalid_o),
                        96'((c == 0) ? 2'b00 : gntSeq2[(c == 0) ? 0 : c - 1]));
            nextCycle();
            if (c == 3) bus2.req_i = 2'b00;
        end

        // Write pass-through
        bus2.req_i = 2'b10;
        bus2.we_i = 2'b10;
        bus2.be_i[1] = 4'b0001;
        bus2.data_i[1] = 32'h0000_0041;
        bus2.addr_i[1] = 32'h0;
        @(negedge clk_i);
        checkOutput("write.gnt", 96'(bus2.gnt_o), 96'(2'b10));
        checkOutput("write.slv_we", 96'(bus2.slv_we_o), 96'(1));
        checkOutput("write.slv_be", 96'(bus2.slv_be_o), 96'(4'b0001));
        checkOutput("write.slv_data", 96'(bus2.slv_data_o), 96'(32'h41));
        nextCycle();
        idleAll();
        @(negedge clk_i);
        checkOutput("write.rvalid", 96'(bus2.rvalid_o), 96'(2'b10));

        // Idle keeps the pointer: favour requester 1, idle, then both request
        nextCycle();
        bus2.req_i = 2'b01;
        @(negedge clk_i);
        checkOutput("idle.pre_gnt", 96'(bus2.gnt_o), 96'(2'b01));
        nextCycle();
        idleAll();
        @(negedge clk_i);
        checkOutput("idle.slv_req", 96'(bus2.slv_req_o), 96'(0));
        checkOutput("idle.slv_bus", 96'({bus2.slv_we_o, bus2.slv_be_o, bus2.slv_addr_o, bus2.slv_data_o}), 96'(0));
        checkOutput("idle.gnt", 96'(bus2.gnt_o), 96'(0));
        nextCycle();
        @(negedge clk_i);
        checkOutput("idle.no_rvalid", 96'(bus2.rvalid_o), 96'(0));
        nextCycle();
        bus2.req_i = 2'b11;
        @(negedge clk_i);
        checkOutput("idle.ptr_held_gnt", 96'(bus2.gnt_o), 96'(2'b10));

        // Reset while a response is pending
        nextCycle();
        bus2.req_i = 2'b01;
        @(negedge clk_i);
        checkOutput("rstmid.gnt", 96'(bus2.gnt_o), 96'(2'b01));
        nextCycle();
        bus2.req_i = 2'b00;
        #2;
        checkOutput("rstmid.pending", 96'(bus2.rvalid_o), 96'(2'b01));
        rst_ni = 1'b0;
        #1;
        checkOutput("rstmid.rvalid_drop", 96'(bus2.rvalid_o), 96'(0));
        checkOutput("rstmid.rdata_drop", 96'(bus2.rdata_o), 96'(0));
        bus2.req_i = 2'b11;
        nextCycle();
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("rstmid.first_gnt", 96'(bus2.gnt_o), 96'(2'b01));
        checkOutput("rstmid.no_replay", 96'(bus2.rvalid_o), 96'(0));

        // Three requesters, 0 and 2 contending
        nextCycle();
        idleAll();
        bus3.req_i = 3'b101;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            checkOutput("nreq3.gnt", 96'(bus3.gnt_o), 96'(gntSeq3[c]));
            checkOutput("nreq3.ptr_range", 96'(dut3.r_rrPtr < 2'd3), 96'(1));
            nextCycle();
        end
        idleAll();

        // Random traffic with occasional asynchronous reset
        repeat (1500) begin
            applyStimulus();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_ni = 1'b0;
                #4 rst_ni = 1'b1;
            end
            nextCycle();
        end

        idleAll();
        @(negedge clk_i);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
